// File: rtl/multicycle_divider_pkg.sv
// multicycle_divider_pkg: shared width and FSM encoding for the iterative divider and its ALU.
package multicycle_divider_pkg;
    localparam int DIV_WIDTH = 32;
    typedef enum logic {DIV_IDLE = 1'b0, DIV_RUN = 1'b1} div_state_t;
endpackage

// File: rtl/multicycle_divider.sv
// multicycle_divider: radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle.
module multicycle_divider
    import multicycle_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             OP_div,
    input  logic             OP_divu,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Stall
);
    localparam int CW = $clog2(WIDTH) + 1;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    div_state_t       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem, q, dvsr, diff;
    logic [WIDTH:0]   shifted;
    logic             neg_q, neg_r, ge;

    // The full remainder is kept in the shift so divisors with the MSB set stay exact.
    assign shifted = {rem, q[WIDTH-1]};
    assign ge      = shifted >= {1'b0, dvsr};
    assign diff    = shifted[WIDTH-1:0] - dvsr;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= DIV_IDLE;
            count <= '0;
            rem   <= '0;
            q     <= '0;
            dvsr  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == DIV_IDLE) begin
            if (OP_div | OP_divu) begin
                state <= DIV_RUN;
                count <= CW'(WIDTH);
                rem   <= '0;
                q     <= OP_div ? mag(Dividend) : Dividend;
                dvsr  <= OP_div ? mag(Divisor) : Divisor;
                neg_q <= OP_div & (Dividend[WIDTH-1] ^ Divisor[WIDTH-1]);
                neg_r <= OP_div & Dividend[WIDTH-1];
            end
        end else begin
            rem   <= ge ? diff : shifted[WIDTH-1:0];
            q     <= {q[WIDTH-2:0], ge};
            count <= count - 1'b1;
            if (count == CW'(1))
                state <= DIV_IDLE;
        end
    end

    assign Stall     = (state == DIV_RUN);
    assign Quotient  = neg_q ? -q : q;
    assign Remainder = neg_r ? -rem : rem;
endmodule
